// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter grant state (idle, master 0 owns, master 1 owns)
//   arb_master_t : master identifier used for round-robin history
//   sel_width()  : byte-select width for a given data width
package wb_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StGnt0,
      StGnt1
   } arb_state_t;

   typedef enum logic {
      M0,
      M1
   } arb_master_t;

   function automatic int unsigned sel_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone B4 pipelined bus bundle.
//   master modport : drives cyc/stb/we/adr/dat_o/sel, receives dat_i/ack/err/stall
//   slave modport  : the reverse view
interface wb_arbiter_2m_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   import wb_arbiter_2m_pkg::*;

   localparam int unsigned SEL_W = sel_width(DATA_W);

   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_o;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] dat_i;
   logic              ack;
   logic              err;
   logic              stall;

   modport master (
      output cyc, stb, we, adr, dat_o, sel,
      input  dat_i, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, adr, dat_o, sel,
      output dat_i, ack, err, stall
   );

endinterface

// File: rtl/wb_arbiter_2m_bus_watchdog.sv
// Bus watchdog: counts cycles a granted strobe waits without a response.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : return the counter to zero
//   i_enable       : strobe outstanding with no response this cycle
//   o_expired      : one-cycle pulse when the wait reaches TIMEOUT cycles
module wb_arbiter_2m_bus_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] r_cnt;
   logic            w_at_limit;

   assign w_at_limit = (r_cnt == CntW'(TIMEOUT));
   // A response arriving in the limit cycle wins over the abort.
   assign o_expired  = w_at_limit & i_enable;

   // Clearing at the limit keeps the counter from ever wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || w_at_limit) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 arbiter with round-robin grant and bus watchdog.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   io_m0          : instruction-fetch master port (slave view)
//   io_m1          : load/store master port (slave view)
//   io_s           : shared downstream slave port (master view)
// Grants are registered and held for the whole cyc burst; slave-side signals
// are a combinational mux of the registered grant.
module wb_arbiter_2m
   import wb_arbiter_2m_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic              i_clk,
   input logic              i_rst_n,
   wb_arbiter_2m_if.slave   io_m0,
   wb_arbiter_2m_if.slave   io_m1,
   wb_arbiter_2m_if.master  io_s
);

   localparam int unsigned SEL_W = sel_width(DATA_W);

   arb_state_t  r_state;
   arb_master_t r_last_owner;

   logic              w_own0;
   logic              w_own1;
   logic              w_own_cyc;
   logic              w_own_stb;
   logic              w_own_we;
   logic [ADDR_W-1:0] w_own_adr;
   logic [DATA_W-1:0] w_own_dat;
   logic [SEL_W-1:0]  w_own_sel;
   logic              w_wd_enable;
   logic              w_abort;

   // Grant FSM. A grant only ever changes in a cycle where the owner's cyc is
   // low (or from idle), so the watchdog clears naturally on every handover.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_last_owner <= M0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_m0.cyc && io_m1.cyc) begin
                  r_state <= (r_last_owner == M0) ? StGnt1 : StGnt0;
               end else if (io_m0.cyc) begin
                  r_state <= StGnt0;
               end else if (io_m1.cyc) begin
                  r_state <= StGnt1;
               end
            end
            StGnt0: begin
               if (!io_m0.cyc) begin
                  r_last_owner <= M0;
                  r_state      <= io_m1.cyc ? StGnt1 : StIdle;
               end
            end
            StGnt1: begin
               if (!io_m1.cyc) begin
                  r_last_owner <= M1;
                  r_state      <= io_m0.cyc ? StGnt0 : StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign w_own0 = (r_state == StGnt0);
   assign w_own1 = (r_state == StGnt1);

   always_comb begin
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      w_own_we  = 1'b0;
      w_own_adr = '0;
      w_own_dat = '0;
      w_own_sel = '0;
      unique case (r_state)
         StGnt0: begin
            w_own_cyc = io_m0.cyc;
            w_own_stb = io_m0.stb;
            w_own_we  = io_m0.we;
            w_own_adr = io_m0.adr;
            w_own_dat = io_m0.dat_o;
            w_own_sel = io_m0.sel;
         end
         StGnt1: begin
            w_own_cyc = io_m1.cyc;
            w_own_stb = io_m1.stb;
            w_own_we  = io_m1.we;
            w_own_adr = io_m1.adr;
            w_own_dat = io_m1.dat_o;
            w_own_sel = io_m1.sel;
         end
         default: ;
      endcase
   end

   assign w_wd_enable = w_own_cyc & w_own_stb & ~io_s.ack & ~io_s.err;

   wb_arbiter_2m_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_bus_watchdog (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (~w_wd_enable),
      .i_enable  (w_wd_enable),
      .o_expired (w_abort)
   );

   // Slave side: the abort cycle withdraws the request from the slave.
   assign io_s.cyc   = w_own_cyc & ~w_abort;
   assign io_s.stb   = w_own_stb & ~w_abort;
   assign io_s.we    = w_own_we;
   assign io_s.adr   = w_own_adr;
   assign io_s.dat_o = w_own_dat;
   assign io_s.sel   = w_own_sel;

   // Master side: only the owner sees responses; the waiting master is stalled.
   assign io_m0.dat_i = io_s.dat_i;
   assign io_m0.ack   = w_own0 & io_s.ack;
   assign io_m0.err   = w_own0 & (io_s.err | w_abort);
   assign io_m0.stall = w_own0 ? io_s.stall : 1'b1;

   assign io_m1.dat_i = io_s.dat_i;
   assign io_m1.ack   = w_own1 & io_s.ack;
   assign io_m1.err   = w_own1 & (io_s.err | w_abort);
   assign io_m1.stall = w_own1 ? io_s.stall : 1'b1;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: a directed vector table plus
// hand-written sequences for reset, handover, bursts, timeout and alternation.
module tb_wb_arbiter_2m;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   localparam logic [31:0] M0_ADR = 32'h0000_0100;
   localparam logic [31:0] M1_ADR = 32'h0000_0200;
   localparam logic [31:0] M0_DAT = 32'hA0A0_A0A0;
   localparam logic [31:0] M1_DAT = 32'h0000_0005;
   localparam logic [31:0] S_DAT  = 32'hDEAD_BEEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   wb_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
   wb_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
   wb_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

   wb_arbiter_2m #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_m0   (m0_bus),
      .io_m1   (m1_bus),
      .io_s    (s_bus)
   );

   // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall}
   // ctl = {s_cyc, s_stb, s_we}
   // rsp = {m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall}
   typedef struct {
      logic [6:0]  in;
      logic [2:0]  ctl;
      logic [31:0] adr;
      logic [5:0]  rsp;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [40:0] RESET_OBS = {3'b000, 32'h0, 6'b001_001};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] in);
      {m0_bus.cyc, m0_bus.stb, m1_bus.cyc, m1_bus.stb, s_bus.ack, s_bus.err, s_bus.stall} = in;
   endtask

   function automatic logic [40:0] observe();
      return {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr,
              m0_bus.ack, m0_bus.err, m0_bus.stall, m1_bus.ack, m1_bus.err, m1_bus.stall};
   endfunction

   // One bus cycle: drive just after the rising edge, sample on the falling edge.
   task automatic cycle(input logic [6:0] in);
      @(posedge clk);
      #1;
      drive(in);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(7'b0);
      @(posedge clk);
      @(negedge clk);
      check("reset_state", 64'(observe()), 64'(RESET_OBS));
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{7'b0000_000, 3'b000, 32'h0,  6'b001_001};
      vecs[1]  = '{7'b1100_000, 3'b000, 32'h0,  6'b001_001};
      vecs[2]  = '{7'b1100_000, 3'b110, M0_ADR, 6'b000_001};
      vecs[3]  = '{7'b1100_001, 3'b110, M0_ADR, 6'b001_001};
      vecs[4]  = '{7'b1100_100, 3'b110, M0_ADR, 6'b100_001};
      vecs[5]  = '{7'b0000_000, 3'b000, M0_ADR, 6'b000_001};
      vecs[6]  = '{7'b1111_000, 3'b000, 32'h0,  6'b001_001};
      vecs[7]  = '{7'b1111_001, 3'b111, M1_ADR, 6'b001_001};
      vecs[8]  = '{7'b1111_100, 3'b111, M1_ADR, 6'b001_100};
      vecs[9]  = '{7'b1100_000, 3'b001, M1_ADR, 6'b001_000};
      vecs[10] = '{7'b1100_100, 3'b110, M0_ADR, 6'b100_001};
      vecs[11] = '{7'b0000_000, 3'b000, M0_ADR, 6'b000_001};
      vecs[12] = '{7'b0011_000, 3'b000, 32'h0,  6'b001_001};
      vecs[13] = '{7'b0011_010, 3'b111, M1_ADR, 6'b001_010};
      vecs[14] = '{7'b0000_000, 3'b001, M1_ADR, 6'b001_000};
      vecs[15] = '{7'b1111_000, 3'b000, 32'h0,  6'b001_001};
      vecs[16] = '{7'b1111_000, 3'b110, M0_ADR, 6'b000_001};
      vecs[17] = '{7'b0011_000, 3'b000, M0_ADR, 6'b000_001};
      vecs[18] = '{7'b0011_000, 3'b111, M1_ADR, 6'b001_000};
      vecs[19] = '{7'b0000_000, 3'b001, M1_ADR, 6'b001_000};

      m0_bus.we = 1'b0; m0_bus.adr = M0_ADR; m0_bus.dat_o = M0_DAT; m0_bus.sel = 4'hF;
      m1_bus.we = 1'b1; m1_bus.adr = M1_ADR; m1_bus.dat_o = M1_DAT; m1_bus.sel = 4'h3;
      s_bus.dat_i = S_DAT;
      drive(7'b0);

      do_reset();

      // Table: single read with ack, tie-break, handover, err pass-through.
      for (int i = 0; i < NVEC; i++) begin
         cycle(vecs[i].in);
         check($sformatf("vec%0d", i), 64'(observe()),
               64'({vecs[i].ctl, vecs[i].adr, vecs[i].rsp}));
         if (i == 4) begin
            check("m0_read_data", 64'(m0_bus.dat_i), 64'(S_DAT));
            check("m0_wdata_sel", 64'({s_bus.dat_o, s_bus.sel}), 64'({M0_DAT, 4'hF}));
         end
         if (i == 8) begin
            check("m1_wdata_sel", 64'({s_bus.dat_o, s_bus.sel}), 64'({M1_DAT, 4'h3}));
         end
      end

      // Simultaneous request after reset: m1 first, then m0 with no idle gap.
      do_reset();
      cycle(7'b1111_000);
      check("tie_idle", 64'(observe()), 64'(RESET_OBS));
      cycle(7'b1111_000);
      check("tie_m1_first", 64'({s_bus.cyc, s_bus.adr}), 64'({1'b1, M1_ADR}));
      cycle(7'b1100_000);
      check("tie_m1_drop", 64'({s_bus.cyc, s_bus.adr}), 64'({1'b0, M1_ADR}));
      cycle(7'b1100_000);
      check("tie_m0_no_gap", 64'({s_bus.cyc, s_bus.adr}), 64'({1'b1, M0_ADR}));

      // m1 burst of 4 acked beats while m0 waits stalled.
      cycle(7'b0000_000);
      cycle(7'b0011_000);
      for (int b = 0; b < 4; b++) begin
         cycle(7'b1111_100);
         check($sformatf("burst_beat%0d", b), 64'(observe()),
               64'({3'b111, M1_ADR, 6'b001_100}));
      end
      cycle(7'b1100_000);
      check("burst_m1_drop", 64'(observe()), 64'({3'b001, M1_ADR, 6'b001_000}));
      cycle(7'b1100_100);
      check("burst_m0_next", 64'(observe()), 64'({3'b110, M0_ADR, 6'b100_001}));
      cycle(7'b0000_000);

      // Timeout: m0 strobe never answered; err exactly TO cycles after first strobe.
      cycle(7'b1100_000);
      for (int k = 0; k <= int'(TO); k++) begin
         cycle(7'b1100_000);
         check($sformatf("timeout_c%0d", k), 64'({s_bus.cyc, s_bus.stb, m0_bus.err}),
               64'((k == int'(TO)) ? 3'b001 : 3'b110));
      end
      cycle(7'b0000_000);
      check("timeout_release", 64'({s_bus.cyc, m0_bus.err}), 64'(2'b00));

      // Continuous requests from both: grants strictly alternate m1, m0, m1 ...
      do_reset();
      cycle(7'b1111_000);
      for (int t = 0; t < 10; t++) begin
         cycle(7'b1111_100);
         check($sformatf("alt_grant%0d", t), 64'({s_bus.cyc, s_bus.adr}),
               64'({1'b1, (t % 2 == 0) ? M1_ADR : M0_ADR}));
         cycle((t % 2 == 0) ? 7'b1100_000 : 7'b0011_000);
      end

      // Reset asserted while m1 owns the bus.
      cycle(7'b0011_100);
      check("pre_reset_own", 64'(observe()), 64'({3'b111, M1_ADR, 6'b001_100}));
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid", 64'(observe()), 64'(RESET_OBS));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(7'b0000_110);
      @(negedge clk);
      check("reset_no_resp", 64'(observe()), 64'(RESET_OBS));
      cycle(7'b0011_000);
      check("reset_idle", 64'(observe()), 64'(RESET_OBS));
      cycle(7'b0011_000);
      check("reset_regrant", 64'({s_bus.cyc, s_bus.adr}), 64'({1'b1, M1_ADR}));
      cycle(7'b0000_000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone B4 arbiter sharing one memory/peripheral slave port between the core's instruction fetch bus (m0) and data load/store bus (m1). Grants are registered, held for the whole `cyc` burst, and alternate round-robin under contention. A bus watchdog terminates stuck cycles with `err` so a missing slave cannot hang the core. It sits between `core` and the system interconnect/RAM.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `SEL_W` = DATA_W/8
- `TIMEOUT`, 255, max cycles a granted strobe may wait for `ack`/`err` (1..65535)

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `m0_cyc, m0_stb, m0_we`  in  1 each  instruction master request
- `m0_adr`  in  ADDR_W ; `m0_dat_o` in DATA_W ; `m0_sel` in SEL_W
- `m0_dat_i`  out  DATA_W  read data (pass-through from slave)
- `m0_ack, m0_err, m0_stall`  out  1 each
- `m1_*`  same set as m0, data master
- `s_cyc, s_stb, s_we`  out  1 each ; `s_adr` out ADDR_W ; `s_dat_o` out DATA_W ; `s_sel` out SEL_W
- `s_dat_i`  in  DATA_W ; `s_ack, s_err, s_stall`  in  1 each

## Operation
- States: `IDLE`, `GNT0`, `GNT1`. Reset -> `IDLE`, `last_owner` = M0 (so first tie goes to M1).
- `IDLE`: if only one `mX_cyc`=1 -> `GNTX`. Both -> grant the master that is not `last_owner`. None -> stay.
- `GNTX`: owner keeps bus while `mX_cyc`=1. When `mX_cyc`=0 at an edge: `last_owner`=X; other master's `cyc`=1 -> go directly to its grant, else `IDLE`.
- Slave outputs: combinational mux from registered grant; in `IDLE` all `s_*` control outputs 0, `s_adr/s_dat_o/s_sel` 0.
- Owner receives `s_ack`, `s_err`, `s_stall`, `s_dat_i`. Non-owner: `ack`=0, `err`=0, `stall`=1, `dat_i` = `s_dat_i` (don't-care).
- `s_cyc` = owner `cyc` gated by `abort`; `s_stb` likewise.
- Watchdog: counter cleared on grant change, on `s_ack`/`s_err`, and when owner `stb`=0; increments while owner `stb`=1 and no response. At count == TIMEOUT: `abort` for one cycle -> owner `err`=1, `s_cyc`=`s_stb`=0, counter clears; grant is retained (master sees err and drops `cyc`).
- Counter width: ceil(log2(TIMEOUT+1)); must not wrap.
- Reset asserted mid-transfer: all state cleared immediately, outputs to reset values; no ack/err emitted.

## Timing
- Reset values: `s_cyc`=`s_stb`=`s_we`=0, `s_adr`/`s_dat_o`/`s_sel`=0, `m0/m1_ack`=`err`=0, `m0/m1_stall`=1.
- Arbitration latency: request seen at edge N -> grant at N, `s_cyc/s_stb` visible in cycle after N (1 cycle from IDLE).
- Handover: owner drops `cyc` at edge N, other master granted at N, drives slave in cycle N+1 (zero idle cycles).
- `ack`/`err`/`dat_i` to owner: combinational, same cycle as slave (0 added latency).
- Timeout: strobe first presented cycle C with no response -> `mX_err` high in cycle C+TIMEOUT.
- Simultaneous: owner drop + new request from same owner -> other master wins if requesting; else same owner regranted via IDLE (1 idle cycle).

## Structure
- `global_pkg`: `arb_state_t` {IDLE, GNT0, GNT1}, `arb_master_t` {M0, M1}.
- Sub-module `bus_watchdog` (counter, clear/enable inputs, `TIMEOUT` parameter, one-cycle `expired` pulse).
- Top: state register, `last_owner`, output muxes.

## Test plan
- Reset, m0 single read of 0x100, slave acks 2 cycles later returning 0xDEADBEEF -> `m0_dat_i`=0xDEADBEEF with `m0_ack`, `m1_stall`=1 throughout.
- m0 and m1 assert `cyc` in same cycle after reset -> m1 granted first; after m1 drops `cyc`, m0 granted next cycle with no idle gap.
- m1 holds `cyc` over 4-beat burst while m0 requests -> m0 stalled until m1 `cyc`=0, never sees ack.
- TIMEOUT=8, slave never acks m0 strobe -> `m0_err`=1 exactly 8 cycles after strobe, `s_cyc`=0 that cycle.
- Alternating continuous requests from both masters for 10 transfers -> grants strictly alternate m1,m0,m1...
- `rst` low mid-transfer while m1 owns -> `s_cyc`=0 immediately, state IDLE, no ack/err on release.
